dma_bus_arbiter: RTL and testbench

Bus-request arbiter between two DMA-capable bus masters and the single Z80 BUSRQ/BUSAK pair. It sits on the CPU side of the DMA handshake:
- merges the masters' `busrq_n` lines into one request to the CPU;
- waits for the CPU's `busak_n`;
- grants the bus to exactly one master;
- returns the bus to the CPU when that master releases it.

It also tracks tenure and asks a long-running holder to yield when the other master is waiting.

---
 rtl/dma_bus_arbiter_if.sv | 21 ++
 rtl/dma_bus_arbiter.sv | 105 ++++++++++
 tb/tb_dma_bus_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_arbiter_if.sv
// Bus-request handshake bundle between two DMA masters, the arbiter and the Z80 BUSRQ/BUSAK pair.
// The arbiter connects through the slave modport; the master modport is the view of the masters and CPU.
interface dma_bus_arbiter_if;
    logic [1:0] req_n;
    logic       cpu_busak_n;
    logic       cpu_busrq_n;
    logic [1:0] grant_n;
    logic       busak_n;
    logic       owner;
    logic       yield;

    modport slave (
        input  req_n, cpu_busak_n,
        output cpu_busrq_n, grant_n, busak_n, owner, yield
    );

    modport master (
        output req_n, cpu_busak_n,
        input  cpu_busrq_n, grant_n, busak_n, owner, yield
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Two-master DMA bus-request arbiter in front of a single Z80 BUSRQ/BUSAK pair, with tenure-based yield hint.
// Define DMA_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise master 0 has fixed priority.
module dma_bus_arbiter #(
    parameter int unsigned MAX_TENURE = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkcpuen,
    dma_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAITAK, GRANT, RELEASE} state_t;

    localparam logic [7:0] MAX_T = 8'(MAX_TENURE);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [7:0] tenure_q, tenure_d;
    logic       tick_q, tick_d;
    logic       busrq_n_q, busrq_n_d;
    logic [1:0] grant_n_q, grant_n_d;
    logic       busak_n_q, busak_n_d;
    logic       yield_q, yield_d;
    logic       pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            tenure_q  <= '0;
            tick_q    <= 1'b0;
            busrq_n_q <= 1'b1;
            grant_n_q <= '1;
            busak_n_q <= 1'b1;
            yield_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            tenure_q  <= tenure_d;
            tick_q    <= tick_d;
            busrq_n_q <= busrq_n_d;
            grant_n_q <= grant_n_d;
            busak_n_q <= busak_n_d;
            yield_q   <= yield_d;
        end
    end

`ifdef DMA_ARB_ROUND_ROBIN_EN
    // Contention goes to whoever was not served last; a lone requester always wins.
    assign pick = (bus.req_n == 2'b00) ? ~last_q : bus.req_n[0];
`else
    assign pick = bus.req_n[0];
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_n != 2'b11) state_d = WAITAK;
            WAITAK:  if (!bus.cpu_busak_n) state_d = bus.req_n[sel_q] ? RELEASE : GRANT;
            GRANT:   if (bus.req_n[owner_q] || bus.cpu_busak_n) state_d = RELEASE;
            RELEASE: if (bus.cpu_busak_n && (tick_q || clkcpuen)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Computes next values of every registered output and datapath register.
    always_comb begin
        sel_d    = sel_q;
        last_d   = last_q;
        owner_d  = owner_q;
        tenure_d = tenure_q;
        tick_d   = 1'b0;
        unique case (state_q)
            IDLE:   sel_d = pick;
            WAITAK: if (state_d == GRANT) begin
                owner_d  = sel_q;
                tenure_d = '0;
            end
            GRANT: begin
                if (clkcpuen && tenure_q != 8'hFF) tenure_d = tenure_q + 8'd1;
                if (bus.req_n[owner_q]) last_d = owner_q;
            end
            RELEASE: tick_d = tick_q | clkcpuen;
            default: ;
        endcase

        busrq_n_d = !(state_d == WAITAK || state_d == GRANT);
        busak_n_d = (state_d != GRANT);
        grant_n_d = '1;
        if (state_d == GRANT) grant_n_d[owner_d] = 1'b0;
        yield_d = (state_q == GRANT) && (state_d == GRANT) &&
                  (tenure_q >= MAX_T) && !bus.req_n[~owner_q];
    end

    assign bus.cpu_busrq_n = busrq_n_q;
    assign bus.grant_n     = grant_n_q;
    assign bus.busak_n     = busak_n_q;
    assign bus.owner       = owner_q;
    assign bus.yield       = yield_q;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter (MAX_TENURE=4); expectations follow DMA_ARB_ROUND_ROBIN_EN.
module tb_dma_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic clkcpuen;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

`ifdef DMA_ARB_ROUND_ROBIN_EN
    localparam logic ARB2_EXP = 1'b1;
`else
    localparam logic ARB2_EXP = 1'b0;
`endif

    dma_bus_arbiter_if bus();

    dma_bus_arbiter #(.MAX_TENURE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .clkcpuen (clkcpuen),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.cpu_busrq_n, bus.grant_n, bus.busak_n});
    endfunction

    // One full tenure: wait for BUSRQ, ack, expect master m granted, release, optionally re-request.
    task automatic serve(input string tag, input logic m, input logic rereq);
        int unsigned i = 0;
        while (bus.cpu_busrq_n !== 1'b0 && i < 8) begin
            step();
            i++;
        end
        check({tag, "_busrq"}, 32'(bus.cpu_busrq_n), 0);
        step(2);
        bus.cpu_busak_n = 1'b0;
        step();
        check({tag, "_owner"}, 32'(bus.owner), 32'(m));
        check({tag, "_grant"}, 32'(bus.grant_n), m ? 32'h1 : 32'h2);
        bus.req_n[m] = 1'b1;
        step();
        check({tag, "_release"}, outs(), 32'hF);
        bus.cpu_busak_n = 1'b1;
        if (rereq) bus.req_n[m] = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        clkcpuen = 1'b1;
        bus.req_n = 2'b11;
        bus.cpu_busak_n = 1'b1;
        step(2);
        check("rst_outs", outs(), 32'hF);
        check("rst_owner", 32'(bus.owner), 0);
        check("rst_yield", 32'(bus.yield), 0);
        rst = 1'b0;
        step();

        // Master 0 alone
        bus.req_n = 2'b10;
        step();
        check("m0_busrq", 32'(bus.cpu_busrq_n), 0);
        check("m0_nogrant", 32'(bus.grant_n), 32'h3);
        step(2);
        bus.cpu_busak_n = 1'b0;
        step();
        check("m0_grant", 32'(bus.grant_n), 32'h2);
        check("m0_busak", 32'(bus.busak_n), 0);
        check("m0_owner", 32'(bus.owner), 0);
        step(2);
        check("m0_noyield", 32'(bus.yield), 0);
        bus.req_n = 2'b11;
        step();
        check("m0_release", outs(), 32'hF);
        check("m0_owner_kept", 32'(bus.owner), 0);
        bus.cpu_busak_n = 1'b1;
        step(2);

        // Both request, back-to-back tenures
        bus.req_n = 2'b00;
        serve("arb1", 1'b0, 1'b1);
        serve("arb2", ARB2_EXP, 1'b1);
        serve("arb3", 1'b0, 1'b0);
        bus.req_n = 2'b11;
        step(2);

        // Tenure limit and yield
        bus.req_n = 2'b10;
        step();
        bus.cpu_busak_n = 1'b0;
        step();
        check("y_grant", 32'(bus.grant_n), 32'h2);
        bus.req_n = 2'b00;
        clkcpuen = 1'b0;
        step(3);
        check("y_gated", 32'(bus.yield), 0);
        clkcpuen = 1'b1;
        step(4);
        check("y_before", 32'(bus.yield), 0);
        step();
        check("y_assert", 32'(bus.yield), 1);
        check("y_nopreempt", 32'(bus.grant_n), 32'h2);
        bus.req_n = 2'b01;
        step();
        check("y_drop", 32'(bus.yield), 0);
        check("y_release", outs(), 32'hF);
        bus.cpu_busak_n = 1'b1;
        serve("y_next", 1'b1, 1'b0);
        step(2);

        // Withdraw in WAITAK
        bus.req_n = 2'b01;
        step();
        check("wd_busrq", 32'(bus.cpu_busrq_n), 0);
        bus.req_n = 2'b11;
        step();
        bus.cpu_busak_n = 1'b0;
        step();
        check("wd_after_ack", outs(), 32'hF);
        bus.cpu_busak_n = 1'b1;
        step(2);
        check("wd_idle", outs(), 32'hF);

        // CPU drops BUSAK during GRANT
        bus.req_n = 2'b10;
        step();
        bus.cpu_busak_n = 1'b0;
        step();
        check("cr_grant", 32'(bus.grant_n), 32'h2);
        step();
        bus.cpu_busak_n = 1'b1;
        step();
        check("cr_drop", outs(), 32'hF);
        step(2);
        check("cr_rerequest", outs(), 32'h7);
        step();
        check("cr_nogrant", 32'(bus.grant_n), 32'h3);
        bus.cpu_busak_n = 1'b0;
        step();
        check("cr_regrant", 32'(bus.grant_n), 32'h2);
        bus.req_n = 2'b11;
        step();
        bus.cpu_busak_n = 1'b1;
        step(2);

        // Asynchronous reset mid-tenure
        bus.req_n = 2'b01;
        step();
        bus.cpu_busak_n = 1'b0;
        step();
        check("ar_owner", 32'(bus.owner), 1);
        bus.req_n = 2'b00;
        step(6);
        check("ar_yield", 32'(bus.yield), 1);
        #2 rst = 1'b1;
        #1;
        check("ar_outs", outs(), 32'hF);
        check("ar_owner0", 32'(bus.owner), 0);
        check("ar_yield0", 32'(bus.yield), 0);
        bus.req_n = 2'b11;
        bus.cpu_busak_n = 1'b1;
        step();
        rst = 1'b0;
        step(2);
        check("ar_idle", outs(), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
